// File: rtl/sprite_host_loader_pkg.sv
// Shared constants and types for the sprite host loader: object table geometry,
// sprite unit control register layout, host bus size codes and FSM encoding.
package sprite_host_loader_pkg;

    // Bytes per object table entry (one 32-bit word per sprite slot)
    localparam int OBJ_BYTES = 4;

    // Default byte address of the sprite unit control register
    localparam logic [5:0] CONTROL_ADDR_DEFAULT = 6'd63;

    // Control register bit positions
    localparam int BITMAP_WRITE_EN = 0;
    localparam int STAGING_READY   = 1;

    // Host bus size codes carried on data_write_n / data_read_n
    localparam logic [1:0] BUS_BYTE = 2'b00;
    localparam logic [1:0] BUS_HALF = 2'b01;
    localparam logic [1:0] BUS_WORD = 2'b10;
    localparam logic [1:0] BUS_NONE = 2'b11;

    // Control word written at commit: staging ready, bitmap writes disabled
    localparam logic [31:0] COMMIT_WORD = (32'd1 << STAGING_READY) & ~(32'd1 << BITMAP_WRITE_EN);

    // Loader sequencing states
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_UPDATE = 2'd1,
        ST_WRITE  = 2'd2,
        ST_COMMIT = 2'd3
    } state_t;

    // Object table entry exactly as it is written to the sprite unit
    typedef struct packed {
        logic [7:0] size;
        logic [7:0] bmp_off;
        logic [7:0] y;
        logic [7:0] x;
    } slot_t;

    // Negate a 4-bit two's-complement velocity; -8 has no positive twin so it becomes +7
    function automatic logic [3:0] neg_sat4(input logic [3:0] v);
        if (v == 4'b1000) begin
            return 4'b0111;
        end else begin
            return 4'd0 - v;
        end
    endfunction

endpackage

// File: rtl/sprite_motion_step.sv
// One frame of motion for a single sprite: add velocity, clamp to the visible
// area (256 x 192) and reflect the velocity component that hit an edge.
module sprite_motion_step
    import sprite_host_loader_pkg::*;
(
    input  logic [7:0] x,
    input  logic [7:0] y,
    input  logic [7:0] size,
    input  logic [3:0] vx,
    input  logic [3:0] vy,
    output logic [7:0] x_nxt,
    output logic [7:0] y_nxt,
    output logic [3:0] vx_nxt,
    output logic [3:0] vy_nxt
);

    logic signed [9:0] nx_s;
    logic signed [9:0] ny_s;
    logic        [7:0] x_lim_s;
    logic        [7:0] y_lim_s;

    // Position candidates and right/bottom limits (256-width = 255-size_hi, 192-height = 191-size_lo)
    always_comb begin
        nx_s    = $signed({2'b00, x}) + $signed({{6{vx[3]}}, vx});
        ny_s    = $signed({2'b00, y}) + $signed({{6{vy[3]}}, vy});
        x_lim_s = 8'd255 - {4'd0, size[7:4]};
        y_lim_s = 8'd191 - {4'd0, size[3:0]};
    end

    // Horizontal clamp and bounce
    always_comb begin
        x_nxt  = x;
        vx_nxt = vx;
        if (nx_s[9]) begin
            x_nxt  = 8'd0;
            vx_nxt = neg_sat4(vx);
        end else if (nx_s > $signed({2'b00, x_lim_s})) begin
            x_nxt  = x_lim_s;
            vx_nxt = neg_sat4(vx);
        end else begin
            x_nxt  = nx_s[7:0];
            vx_nxt = vx;
        end
    end

    // Vertical clamp and bounce
    always_comb begin
        y_nxt  = y;
        vy_nxt = vy;
        if (ny_s[9]) begin
            y_nxt  = 8'd0;
            vy_nxt = neg_sat4(vy);
        end else if (ny_s > $signed({2'b00, y_lim_s})) begin
            y_nxt  = y_lim_s;
            vy_nxt = neg_sat4(vy);
        end else begin
            y_nxt  = ny_s[7:0];
            vy_nxt = vy;
        end
    end

endmodule

// File: rtl/sprite_host_loader.sv
// Host-side sprite loader: on a sprite unit interrupt, advances every slot by one
// frame of motion, streams the object table to the sprite unit and commits it
// through the control register. Slots are configured while idle.
module sprite_host_loader #(
    parameter int         MAX_SPRITES  = 8,
    parameter logic [5:0] CONTROL_ADDR = sprite_host_loader_pkg::CONTROL_ADDR_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        user_interrupt,
    input  logic        cfg_we,
    input  logic [2:0]  cfg_idx,
    input  logic [31:0] cfg_data,
    input  logic [7:0]  cfg_vel,
    output logic        cfg_ready,
    output logic [5:0]  address,
    output logic [31:0] data_out,
    output logic [1:0]  data_write_n,
    output logic [1:0]  data_read_n,
    output logic        busy,
    output logic [15:0] frame_count,
    output logic [7:0]  overrun_count
);
    import sprite_host_loader_pkg::*;

    localparam int                IDX_W    = (MAX_SPRITES > 1) ? $clog2(MAX_SPRITES) : 1;
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(MAX_SPRITES - 1);

    state_t           state_r;
    state_t           state_nxt_s;
    logic [IDX_W-1:0] idx_r;
    logic [IDX_W-1:0] idx_nxt_s;
    logic             pending_r;

    slot_t            slot_r [MAX_SPRITES];
    logic [7:0]       vel_r  [MAX_SPRITES];

    logic             irq_s;
    logic             start_s;
    logic             overrun_s;

    slot_t            cur_slot_s;
    logic [7:0]       cur_vel_s;
    slot_t            step_slot_s;
    logic [3:0]       step_vx_s;
    logic [3:0]       step_vy_s;
    slot_t            wr_slot_s;

    logic [5:0]       addr_nxt_s;
    logic [31:0]      data_nxt_s;
    logic [1:0]       wn_nxt_s;

    logic [5:0]       address_r;
    logic [31:0]      data_out_r;
    logic [1:0]       data_write_n_r;
    logic             busy_r;
    logic             cfg_ready_r;
    logic [15:0]      frame_count_r;
    logic [7:0]       overrun_count_r;

    assign irq_s     = user_interrupt & enable;
    assign start_s   = (state_r == ST_IDLE) & (irq_s | pending_r);
    assign overrun_s = irq_s & (state_r != ST_IDLE);

    assign cur_slot_s = slot_r[idx_r];
    assign cur_vel_s  = vel_r[idx_r];

    sprite_motion_step u_motion (
        .x      (cur_slot_s.x),
        .y      (cur_slot_s.y),
        .size   (cur_slot_s.size),
        .vx     (cur_vel_s[3:0]),
        .vy     (cur_vel_s[7:4]),
        .x_nxt  (step_slot_s.x),
        .y_nxt  (step_slot_s.y),
        .vx_nxt (step_vx_s),
        .vy_nxt (step_vy_s)
    );
    assign step_slot_s.size    = cur_slot_s.size;
    assign step_slot_s.bmp_off = cur_slot_s.bmp_off;

    // Next state and slot index: fixed-length UPDATE and WRITE sweeps, one-cycle COMMIT
    always_comb begin
        state_nxt_s = state_r;
        idx_nxt_s   = idx_r;
        case (state_r)
            ST_IDLE: begin
                idx_nxt_s = '0;
                if (start_s) begin
                    state_nxt_s = ST_UPDATE;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_UPDATE: begin
                if (idx_r == LAST_IDX) begin
                    state_nxt_s = ST_WRITE;
                    idx_nxt_s   = '0;
                end else begin
                    idx_nxt_s   = idx_r + IDX_W'(1);
                end
            end
            ST_WRITE: begin
                if (idx_r == LAST_IDX) begin
                    state_nxt_s = ST_COMMIT;
                    idx_nxt_s   = '0;
                end else begin
                    idx_nxt_s   = idx_r + IDX_W'(1);
                end
            end
            ST_COMMIT: begin
                state_nxt_s = ST_IDLE;
                idx_nxt_s   = '0;
            end
            default: begin
                state_nxt_s = ST_IDLE;
                idx_nxt_s   = '0;
            end
        endcase
    end

    // Slot feeding the first word write; forwards the in-flight update when a sweep is one slot long
    always_comb begin
        if ((state_r == ST_UPDATE) && (idx_r == idx_nxt_s)) begin
            wr_slot_s = step_slot_s;
        end else begin
            wr_slot_s = slot_r[idx_nxt_s];
        end
    end

    // Bus values for the coming cycle, registered below so the bus is glitch-free
    always_comb begin
        addr_nxt_s = 6'd0;
        data_nxt_s = 32'd0;
        wn_nxt_s   = BUS_NONE;
        case (state_nxt_s)
            ST_WRITE: begin
                addr_nxt_s = 6'(int'(idx_nxt_s) * OBJ_BYTES);
                data_nxt_s = wr_slot_s;
                wn_nxt_s   = BUS_WORD;
            end
            ST_COMMIT: begin
                addr_nxt_s = CONTROL_ADDR;
                data_nxt_s = COMMIT_WORD;
                wn_nxt_s   = BUS_BYTE;
            end
            default: begin
                addr_nxt_s = 6'd0;
                data_nxt_s = 32'd0;
                wn_nxt_s   = BUS_NONE;
            end
        endcase
    end

    // FSM state, sweep index and collapsed pending service request
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            idx_r     <= '0;
            pending_r <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            idx_r   <= idx_nxt_s;
            if (overrun_s) begin
                pending_r <= 1'b1;
            end else if (start_s) begin
                pending_r <= 1'b0;
            end
        end
    end

    // Slot storage: motion results during UPDATE, host configuration only while idle
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < MAX_SPRITES; i++) begin
                slot_r[i] <= '0;
                vel_r[i]  <= 8'd0;
            end
        end else if (state_r == ST_UPDATE) begin
            slot_r[idx_r] <= step_slot_s;
            vel_r[idx_r]  <= {step_vy_s, step_vx_s};
        end else if (cfg_we && (state_r == ST_IDLE)) begin
            slot_r[cfg_idx] <= cfg_data;
            vel_r[cfg_idx]  <= cfg_vel;
        end
    end

    // Registered host bus and status outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            address_r      <= 6'd0;
            data_out_r     <= 32'd0;
            data_write_n_r <= BUS_NONE;
            busy_r         <= 1'b0;
            cfg_ready_r    <= 1'b1;
        end else begin
            address_r      <= addr_nxt_s;
            data_out_r     <= data_nxt_s;
            data_write_n_r <= wn_nxt_s;
            busy_r         <= (state_nxt_s != ST_IDLE);
            cfg_ready_r    <= (state_nxt_s == ST_IDLE);
        end
    end

    // Completed-frame counter (wrapping) and overrun counter (saturating)
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            frame_count_r   <= 16'd0;
            overrun_count_r <= 8'd0;
        end else begin
            if (state_r == ST_COMMIT) begin
                frame_count_r <= frame_count_r + 16'd1;
            end
            if (overrun_s && (overrun_count_r != 8'hFF)) begin
                overrun_count_r <= overrun_count_r + 8'd1;
            end
        end
    end

    assign address       = address_r;
    assign data_out      = data_out_r;
    assign data_write_n  = data_write_n_r;
    assign data_read_n   = BUS_NONE;
    assign busy          = busy_r;
    assign cfg_ready     = cfg_ready_r;
    assign frame_count   = frame_count_r;
    assign overrun_count = overrun_count_r;

endmodule

// File: tb/tb_sprite_host_loader.sv
// Directed bench for sprite_host_loader: a table of slot configurations with
// hand-computed object-table words for four consecutive frames, plus sequences
// for overrun/pending, disabled interrupts and reset during a write sweep.
module tb_sprite_host_loader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic        user_interrupt;
    logic        cfg_we;
    logic [2:0]  cfg_idx;
    logic [31:0] cfg_data;
    logic [7:0]  cfg_vel;
    logic        cfg_ready;
    logic [5:0]  address;
    logic [31:0] data_out;
    logic [1:0]  data_write_n;
    logic [1:0]  data_read_n;
    logic        busy;
    logic [15:0] frame_count;
    logic [7:0]  overrun_count;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [2:0]       idx;
        logic [31:0]      data;
        logic [7:0]       vel;
        logic [3:0][31:0] expw;   // expw[f] = word expected in frame f (0-based)
    } vec_t;

    vec_t vecs [8];

    sprite_host_loader dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .enable         (enable),
        .user_interrupt (user_interrupt),
        .cfg_we         (cfg_we),
        .cfg_idx        (cfg_idx),
        .cfg_data       (cfg_data),
        .cfg_vel        (cfg_vel),
        .cfg_ready      (cfg_ready),
        .address        (address),
        .data_out       (data_out),
        .data_write_n   (data_write_n),
        .data_read_n    (data_read_n),
        .busy           (busy),
        .frame_count    (frame_count),
        .overrun_count  (overrun_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Called just after a negedge. Optionally raises the interrupt for the next
    // edge E, then checks the bus in cycles E+1..E+18 and applies scripted events.
    task automatic run_frame(input logic raise, input int fr, input logic zero);
        logic [43:0] exp_v;
        logic [31:0] w;
        user_interrupt = raise;
        @(posedge clk);
        for (int k = 1; k <= 18; k++) begin
            @(negedge clk);
            user_interrupt = 1'b0;
            cfg_we         = 1'b0;
            if (k <= 8) begin
                exp_v = {1'b1, 1'b0, 2'b11, 2'b11, 6'd0, 32'd0};
            end else if (k <= 16) begin
                w     = zero ? 32'd0 : vecs[k-9].expw[fr];
                exp_v = {1'b1, 1'b0, 2'b11, 2'b10, 6'((k - 9) * 4), w};
            end else if (k == 17) begin
                exp_v = {1'b1, 1'b0, 2'b11, 2'b00, 6'd63, 32'h0000_0002};
            end else begin
                exp_v = {1'b0, 1'b1, 2'b11, 2'b11, 6'd0, 32'd0};
            end
            check($sformatf("frame%0d_cycle%0d", fr, k),
                  {20'd0, busy, cfg_ready, data_read_n, data_write_n, address, data_out},
                  {20'd0, exp_v});
            if (!zero && fr == 1) begin
                if (k == 4)  enable = 1'b0;
                if (k == 6)  user_interrupt = 1'b1;
                if (k == 18) enable = 1'b1;
            end
            if (!zero && fr == 2) begin
                if (k == 3) user_interrupt = 1'b1;
                if (k == 10) begin
                    user_interrupt = 1'b1;
                    cfg_we   = 1'b1;
                    cfg_idx  = 3'd0;
                    cfg_data = 32'hDEAD_BEEF;
                    cfg_vel  = 8'h55;
                end
            end
        end
    endtask

    initial begin
        rst_n          = 1'b0;
        enable         = 1'b1;
        user_interrupt = 1'b0;
        cfg_we         = 1'b0;
        cfg_idx        = 3'd0;
        cfg_data       = 32'd0;
        cfg_vel        = 8'd0;

        vecs[0] = '{3'd0, 32'h3300_140A, 8'hE3, {32'h3300_0C16, 32'h3300_0E13, 32'h3300_1010, 32'h3300_120D}};
        vecs[1] = '{3'd1, 32'h7011_64FA, 8'h04, {32'h7011_64EC, 32'h7011_64F0, 32'h7011_64F4, 32'h7011_64F8}};
        vecs[2] = '{3'd2, 32'h0022_0105, 8'h80, {32'h0022_1505, 32'h0022_0E05, 32'h0022_0705, 32'h0022_0005}};
        vecs[3] = '{3'd3, 32'hFF33_0000, 8'h08, {32'hFF33_0015, 32'hFF33_000E, 32'hFF33_0007, 32'hFF33_0000}};
        vecs[4] = '{3'd4, 32'hFF44_B0F0, 8'h77, {32'hFF44_9BDB, 32'hFF44_A2E2, 32'hFF44_A9E9, 32'hFF44_B0F0}};
        vecs[5] = '{3'd5, 32'h1255_3264, 8'h1F, {32'h1255_3660, 32'h1255_3561, 32'h1255_3462, 32'h1255_3363}};
        vecs[6] = '{3'd6, 32'h1066_BEFC, 8'h12, {32'h1066_BDFA, 32'h1066_BEFC, 32'h1066_BFFE, 32'h1066_BFFE}};
        vecs[7] = '{3'd7, 32'd0,         8'h00, {32'd0, 32'd0, 32'd0, 32'd0}};

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_bus", {20'd0, busy, cfg_ready, data_read_n, data_write_n, address, data_out},
              {20'd0, 1'b0, 1'b1, 2'b11, 2'b11, 6'd0, 32'd0});
        check("reset_counters", {40'd0, frame_count, overrun_count}, 64'd0);
        rst_n = 1'b1;

        // Configure slots 0..5; slot 6 goes in the same cycle as the interrupt
        for (int i = 0; i < 6; i++) begin
            check($sformatf("cfg_ready_slot%0d", i), {63'd0, cfg_ready}, 64'd1);
            cfg_we   = 1'b1;
            cfg_idx  = vecs[i].idx;
            cfg_data = vecs[i].data;
            cfg_vel  = vecs[i].vel;
            @(negedge clk);
        end
        cfg_we   = 1'b1;
        cfg_idx  = vecs[6].idx;
        cfg_data = vecs[6].data;
        cfg_vel  = vecs[6].vel;
        run_frame(1'b1, 0, 1'b0);
        check("frames_after_1", {48'd0, frame_count}, 64'd1);

        // Frame 2: enable drops mid-service and an interrupt arrives while disabled
        run_frame(1'b1, 1, 1'b0);
        check("frames_after_2", {48'd0, frame_count}, 64'd2);
        check("overrun_after_2", {56'd0, overrun_count}, 64'd0);

        // Frame 3: two overrun interrupts and a refused cfg write; frame 4 follows from pending
        run_frame(1'b1, 2, 1'b0);
        run_frame(1'b0, 3, 1'b0);
        check("frames_after_4", {48'd0, frame_count}, 64'd4);
        check("overrun_after_4", {56'd0, overrun_count}, 64'd2);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check($sformatf("no_extra_service%0d", k), {62'd0, busy, cfg_ready}, 64'd1);
        end

        // Interrupts with enable low are ignored entirely
        enable         = 1'b0;
        user_interrupt = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (k == 2) user_interrupt = 1'b0;
            check($sformatf("disabled_idle%0d", k), {60'd0, busy, cfg_ready, data_write_n}, {60'd0, 4'b0111});
        end
        check("disabled_counters", {40'd0, frame_count, overrun_count}, {40'd0, 16'd4, 8'd2});
        enable = 1'b1;

        // Reset in the middle of the write sweep: bus idles at once, no commit follows
        user_interrupt = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= 24; k++) begin
            @(negedge clk);
            user_interrupt = 1'b0;
            if (k == 11) begin
                check("pre_reset_write", {56'd0, data_write_n, address}, {56'd0, 2'b10, 6'd8});
            end
            if (k >= 13) begin
                check($sformatf("reset_sweep%0d", k), {55'd0, busy, data_write_n, address},
                      {55'd0, 1'b0, 2'b11, 6'd0});
            end
            if (k == 12) rst_n = 1'b0;
            if (k == 14) rst_n = 1'b1;
        end
        check("reset_sweep_counters", {40'd0, frame_count, overrun_count}, 64'd0);

        // Slots were cleared by the reset: every word of the next frame is zero
        run_frame(1'b1, 0, 1'b1);
        check("frames_after_reset_frame", {48'd0, frame_count}, 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
